// File: rtl/au_sequencer_if.sv
// au_sequencer_if: request, operand and result handshakes of the arithmetic-unit sequencer
// master drives: req_valid, req_op, opnd_valid, res_ready
// slave drives:  req_ready, opnd_ready, res_valid, err, busy
interface au_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       opnd_valid;
  logic       opnd_ready;
  logic       res_valid;
  logic       res_ready;
  logic       err;
  logic       busy;
  modport master (output req_valid, req_op, opnd_valid, res_ready,
                  input  req_ready, opnd_ready, res_valid, err, busy);
  modport slave  (input  req_valid, req_op, opnd_valid, res_ready,
                  output req_ready, opnd_ready, res_valid, err, busy);
endinterface

// File: rtl/au_sequencer.sv
// au_sequencer: FSM controller for arithmetic_unit (add/sub in one step, radix-2 Booth mul, div rejected)
// clk, rst (sync, active-low); bus: request/operand/result handshakes plus err/busy
// op: latched operation; c0..c7: datapath controls; cnt_done, q0, qm1, a7: datapath status
// OPND_TIMEOUT: cycles to wait for each operand, 0 waits forever
module au_sequencer #(
  parameter int OPND_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  au_sequencer_if.slave bus,
  output logic [1:0] op,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  input  logic       cnt_done,
  input  logic       q0,
  input  logic       qm1,
  input  logic       a7
);
  typedef enum logic [2:0] {IDLE, LD_M, LD_Q, EXAM, SHIFT, RES, ERR} state_t;
  localparam logic [15:0] TLIM = 16'(OPND_TIMEOUT - 1);
  state_t      state, state_nx;
  logic [15:0] tcnt;
  logic        tmo;
  assign tmo = (OPND_TIMEOUT != 0) && (tcnt == TLIM);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      op    <= 2'b00;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req_valid) op <= bus.req_op;
      // counts waiting cycles in an operand state; any handshake or other state clears it
      tcnt  <= (bus.opnd_ready && !bus.opnd_valid) ? tcnt + 16'd1 : '0;
    end
  end
  // every output is forced low while rst is asserted, whatever state is still held
  always_comb begin
    bus.req_ready  = rst && state == IDLE;
    bus.opnd_ready = rst && (state == LD_M || state == LD_Q);
    bus.res_valid  = rst && state == RES;
    bus.err        = rst && state == ERR;
    bus.busy       = rst && state != IDLE;
    c0 = rst && state == LD_M && bus.opnd_valid;
    c1 = rst && state == LD_Q && bus.opnd_valid;
    c2 = rst && state == EXAM && (q0 ^ qm1);
    c3 = rst && ((state == EXAM && q0 && !qm1) || (state == RES && op == 2'b01));
    c4 = rst && state == SHIFT;
    c5 = c4;
    c6 = c4 && a7;
    c7 = bus.res_valid;
    state_nx = IDLE;
    case (state)
      IDLE:  state_nx = bus.req_valid ? (bus.req_op == 2'b11 ? ERR : LD_M) : IDLE;
      LD_M:  state_nx = bus.opnd_valid ? LD_Q : (tmo ? ERR : LD_M);
      LD_Q:  state_nx = bus.opnd_valid ? (op == 2'b10 ? EXAM : RES) : (tmo ? ERR : LD_Q);
      EXAM:  state_nx = SHIFT;
      SHIFT: state_nx = cnt_done ? RES : EXAM;
      RES:   state_nx = bus.res_ready ? IDLE : RES;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_au_sequencer.sv
// tb_au_sequencer: randomized self-checking bench with a behavioural arithmetic_unit and a plain-arithmetic result reference
module tb_au_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] op;
  logic       c0, c1, c2, c3, c4, c5, c6, c7;
  logic       cnt_done, q0, qm1, a7;
  logic [7:0] din = 8'h00;
  logic [7:0] m_r, a_r, q_r;
  logic       qm1_r;
  logic [2:0] cnt_r;
  logic [8:0] s9;
  logic [15:0] z;
  logic [7:0] cvec;
  int total = 0, bad = 0;
  int n_c0 = 0, n_c1 = 0, n_c4 = 0, n_cc = 0, n_idle_c = 0;
  always #5 clk = ~clk;
  au_sequencer_if bus();
  au_sequencer #(.OPND_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .op(op),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .cnt_done(cnt_done), .q0(q0), .qm1(qm1), .a7(a7)
  );
  // arithmetic_unit stand-in: reacts only to the control lines
  always @(posedge clk) begin
    if (c0) begin m_r <= din; a_r <= 8'h00; q_r <= 8'h00; qm1_r <= 1'b0; cnt_r <= 3'd0; end
    if (c1) q_r <= din;
    if (c2) a_r <= c3 ? a_r - m_r : a_r + m_r;
    if (c4 && c5) begin
      a_r   <= {c6, a_r[7:1]};
      q_r   <= {a_r[0], q_r[7:1]};
      qm1_r <= q_r[0];
      cnt_r <= cnt_r + 3'd1;
    end
  end
  assign q0 = q_r[0];
  assign qm1 = qm1_r;
  assign a7 = a_r[7];
  assign cnt_done = cnt_r == 3'd7;
  assign s9 = c3 ? {q_r[7], q_r} - {m_r[7], m_r} : {q_r[7], q_r} + {m_r[7], m_r};
  assign z = (op == 2'b10) ? {a_r, q_r} : {{7{s9[8]}}, s9};
  assign cvec = {c7, c6, c5, c4, c3, c2, c1, c0};
  always @(negedge clk) begin
    n_c0 += int'(c0);
    n_c1 += int'(c1);
    n_c4 += int'(c4);
    if (c0 && c1) n_cc++;
    if (!bus.busy && |cvec) n_idle_c++;
  end
  function automatic logic [15:0] exp_z(input logic [1:0] o, input logic [7:0] m, input logic [7:0] q);
    int sm, sq;
    sm = int'($signed(m));
    sq = int'($signed(q));
    return o == 2'b00 ? 16'(sq + sm) : o == 2'b01 ? 16'(sq - sm) : 16'(sm * sq);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(input string tag, input logic [1:0] o, input logic [7:0] m, input logic [7:0] q,
                         input int dm, input int dq, input int hold);
    int lat, g, b0, b1, b4, elat;
    logic [15:0] zx, zv;
    zx = exp_z(o, m, q);
    elat = (o == 2'b10 ? 19 : 3) + dm + dq;
    b0 = n_c0; b1 = n_c1; b4 = n_c4;
    bus.req_op = o;
    bus.req_valid = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 20) begin step(); g++; end
    step();
    bus.req_valid = 1'b0;
    lat = 1;
    repeat (dm) begin step(); lat++; end
    din = m; bus.opnd_valid = 1'b1; step(); lat++; bus.opnd_valid = 1'b0;
    repeat (dq) begin step(); lat++; end
    din = q; bus.opnd_valid = 1'b1; step(); lat++; bus.opnd_valid = 1'b0;
    g = 0;
    while (!bus.res_valid && g < 40) begin step(); lat++; g++; end
    total++;
    if (lat !== elat) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, elat); end
    zv = z;
    total++;
    if (zv !== zx) begin bad++; $display("FAIL %s z: got %h want %h", tag, zv, zx); end
    total++;
    if (n_c0 - b0 !== 1 || n_c1 - b1 !== 1) begin
      bad++; $display("FAIL %s c0/c1 pulses: got %0d/%0d want 1/1", tag, n_c0 - b0, n_c1 - b1);
    end
    total++;
    if (n_c4 - b4 !== (o == 2'b10 ? 8 : 0)) begin
      bad++; $display("FAIL %s c4 pulses: got %0d want %0d", tag, n_c4 - b4, o == 2'b10 ? 8 : 0);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if (bus.res_valid !== 1'b1 || z !== zv || c4 !== 1'b0 || c5 !== 1'b0) begin
        bad++; $display("FAIL %s hold %0d: got valid=%b z=%h c4=%b c5=%b want valid=1 z=%h c4=0 c5=0",
                        tag, i, bus.res_valid, z, c4, c5, zv);
      end
    end
    total++;
    if (c3 !== (o == 2'b01) || c7 !== 1'b1) begin
      bad++; $display("FAIL %s res controls: got c3=%b c7=%b want c3=%b c7=1", tag, c3, c7, o == 2'b01);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    total++;
    if (bus.req_ready !== 1'b1 || op !== o) begin
      bad++; $display("FAIL %s back to idle: got req_ready=%b op=%b want 1 %b", tag, bus.req_ready, op, o);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    total++;
    if (cvec !== 8'h00) begin bad++; $display("FAIL reset c: got %h want 00", cvec); end
    total++;
    if ({bus.req_ready, bus.opnd_ready, bus.res_valid, bus.err, bus.busy} !== 5'b0) begin
      bad++; $display("FAIL reset handshakes: got %b want 00000",
                      {bus.req_ready, bus.opnd_ready, bus.res_valid, bus.err, bus.busy});
    end
    rst = 1'b1;
    step();
    total++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || op !== 2'b00) begin
      bad++; $display("FAIL reset release: got req_ready=%b busy=%b op=%b want 1 0 00", bus.req_ready, bus.busy, op);
    end
  endtask
  task automatic test_directed();
    run_txn("add", 2'b00, 8'h05, 8'h03, 0, 0, 0);
    run_txn("sub", 2'b01, 8'h05, 8'h03, 0, 0, 3);
    run_txn("mul_neg", 2'b10, 8'h07, 8'hFD, 0, 0, 0);
    run_txn("mul_max", 2'b10, 8'h7F, 8'h7F, 0, 0, 0);
    run_txn("mul_qmin", 2'b10, 8'h7F, 8'h80, 0, 0, 0);
  endtask
  task automatic test_backpressure();
    run_txn("backpressure", 2'b10, 8'hA5, 8'h3C, 0, 0, 10);
  endtask
  task automatic test_slow_operands();
    run_txn("slow_ok", 2'b00, 8'h80, 8'h80, 3, 3, 1);
  endtask
  task automatic test_div();
    int b0;
    b0 = n_c0;
    bus.req_op = 2'b11;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || cvec !== 8'h00 || op !== 2'b11) begin
      bad++; $display("FAIL div err: got err=%b busy=%b req_ready=%b c=%h op=%b want 1 1 0 00 11",
                      bus.err, bus.busy, bus.req_ready, cvec, op);
    end
    step();
    total++;
    if (bus.err !== 1'b0 || bus.req_ready !== 1'b1 || n_c0 !== b0) begin
      bad++; $display("FAIL div return: got err=%b req_ready=%b c0s=%0d want 0 1 0", bus.err, bus.req_ready, n_c0 - b0);
    end
  endtask
  task automatic test_timeout();
    int g;
    bus.req_op = 2'b00;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    g = 0;
    while (bus.opnd_ready && g < 20) begin g++; step(); end
    total++;
    if (g !== 4 || bus.err !== 1'b1) begin
      bad++; $display("FAIL timeout: got wait=%0d err=%b want 4 1", g, bus.err);
    end
    step();
    total++;
    if (bus.err !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL timeout return: got err=%b req_ready=%b want 0 1", bus.err, bus.req_ready);
    end
  endtask
  task automatic test_reset_abort();
    int g, b4;
    b4 = n_c4;
    bus.req_op = 2'b10;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    din = 8'h11; bus.opnd_valid = 1'b1; step();
    din = 8'h22; step(); bus.opnd_valid = 1'b0;
    g = 0;
    while (!(c4 && n_c4 - b4 == 3) && g < 40) begin step(); g++; end
    total++;
    if (g >= 40) begin bad++; $display("FAIL abort reach shift4: got timeout want shift"); end
    rst = 1'b0;
    step();
    total++;
    if (cvec !== 8'h00 || {bus.busy, bus.res_valid, bus.err, bus.opnd_ready} !== 4'b0) begin
      bad++; $display("FAIL abort outputs: got c=%h busy=%b res_valid=%b err=%b want all 0",
                      cvec, bus.busy, bus.res_valid, bus.err);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || op !== 2'b00) begin
      bad++; $display("FAIL abort idle: got req_ready=%b op=%b want 1 00", bus.req_ready, op);
    end
    step();
    run_txn("after_abort", 2'b00, 8'h3A, 8'hC9, 0, 0, 0);
  endtask
  task automatic test_back_to_back();
    logic [1:0] o;
    logic [7:0] m, q;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 2));
      m = 8'($urandom);
      q = 8'($urandom);
      if (o == 2'b10 && m == 8'h80) m = 8'h81;
      run_txn("random", o, m, q, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.opnd_valid = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_slow_operands();
    test_div();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    step();
    total++;
    if (n_cc !== 0) begin bad++; $display("FAIL c0_c1_overlap: got %0d want 0", n_cc); end
    total++;
    if (n_idle_c !== 0) begin bad++; $display("FAIL c_while_idle: got %0d want 0", n_idle_c); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
